int_controller: RTL and testbench
=================================

Name: int_controller

Overview:
- Interrupt controller between the interrupt sources and the CPU core.
- Sources: t1_interrupt, t2_interrupt, uart_rx_interrupt and frameDrawn, concatenated on int_in[3:0] in that order.
- Synchronises each source, detects rising edges, and latches them as pending.
- Masks, prioritises and presents one interrupt at a time to the CPU over an irq/ack/eoi handshake.

Parameters:
N_INT, 4, number of interrupt sources (2..8)
ID_W, 2, width of irq_id; must be at least clog2(N_INT)
SYNC_STAGES, 2, flops in each input synchroniser (frameDrawn originates in the vga_clk domain)
MASK_RESET, 4'b1111, enable-mask value after reset (N_INT bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
int_in  in  N_INT  raw level interrupt sources; bit 0 = t1_interrupt, 1 = t2_interrupt, 2 = uart_rx_interrupt, 3 = frameDrawn
mask_we  in  1  one-cycle write strobe for the mask register
mask_d  in  N_INT  new mask value; 1 = source enabled
mask_q  out  N_INT  current mask
pending_q  out  N_INT  current pending bits, unmasked
irq  out  1  interrupt request to the CPU (registered)
irq_id  out  ID_W  index of the presented source; valid while irq = 1
ack  in  1  CPU accepts the presented interrupt; one-cycle pulse
eoi  in  1  end of interrupt, issued by the CPU at return-from-interrupt; one-cycle pulse
in_service  out  1  high from accepted ack until eoi

Behaviour:
- Reset (asynchronous, active-high) forces:
  - synchronisers, edge-detect registers and pending to 0
  - irq = 0, irq_id = 0, in_service = 0
  - mask_q = MASK_RESET
- Synchroniser: each int_in bit passes through a SYNC_STAGES-flop chain. s[i] denotes the last flop of that chain.
- Edge detect: the register d[i] holds the previous value of s[i]. rise[i] = s[i] & ~d[i].
  - A level held high produces exactly one rise.
  - A new rise requires s[i] to return low for at least 1 cycle.
- Pending update on each clk edge:
  - pending[i] <= (pending[i] & ~clr[i]) | rise[i]
  - clr[i] = ack & irq & (irq_id == i)
  - Set wins: a rise on the source being acked in the same cycle leaves pending[i] = 1.
- Request selection, combinational: cand = pending & mask_q. sel = lowest index set in cand (bit 0 has highest priority).
- Request register states:
  - IDLE (irq = 0, in_service = 0):
    - If cand != 0 and no accepted ack this cycle: next cycle irq = 1, irq_id = sel.
    - Otherwise stay in IDLE.
  - PRESENT (irq = 1):
    - irq_id is frozen. A higher-priority arrival, or a mask write clearing the presented bit, does not change or retract the request.
    - On ack = 1: next cycle irq = 0, in_service = 1; go to SERVICE.
    - Without ack, irq stays high indefinitely.
  - SERVICE (in_service = 1, irq = 0):
    - No new request is presented; pending bits continue to accumulate.
    - On eoi = 1: next cycle in_service = 0; go to IDLE.
    - A request may then assert 1 cycle later still, so the minimum gap from eoi to irq is 2 cycles.
- Ignored inputs:
  - ack while irq = 0 has no effect.
  - eoi while in_service = 0 has no effect.
  - ack and eoi in the same cycle can only be legal from PRESENT, where eoi is ignored.
- Latency: a rising edge sampled at clk edge k gives:
  - s high after edge k+SYNC_STAGES-1
  - pending set at edge k+SYNC_STAGES
  - irq high at edge k+SYNC_STAGES+1 (3 cycles with defaults), provided the controller is in IDLE and the source is enabled.
- Mask register:
  - mask_we loads mask_d on the next edge; mask_q is the register output.
  - Masked sources still latch pending; unmasking later raises irq if the controller is in IDLE.
- Pending bits are never lost. Rises arriving during PRESENT or SERVICE stay latched; a repeated rise on an already-pending source merges into one pending bit.
- Reset mid-operation (PRESENT or SERVICE) returns to IDLE immediately and discards all pending bits.

Test Plan:
- Single source: reset, then int_in = 4'b0001 held high from cycle 0 -> pending_q = 0001 after 2 edges; irq = 1 with irq_id = 0 at edge 3 and held. ack at cycle 6 -> irq = 0, in_service = 1, pending_q = 0000. eoi -> in_service = 0; no further irq while int_in stays high.
- Priority: int_in bits 3 and 1 rise in the same cycle -> irq_id = 1. ack, then eoi -> irq reasserts 2 cycles after eoi with irq_id = 3.
- Freeze: irq presented with irq_id = 2, then bit 0 rises -> irq_id stays 2 until ack. After eoi, the next request has irq_id = 0.
- Mask: mask_d = 4'b0111 written, then frameDrawn (bit 3) rises -> pending_q = 1000, irq stays 0. Write mask 4'b1111 -> irq = 1, irq_id = 3 on the following edge.
- Set-wins: pulse bit 2 high 1 cycle, low 1 cycle, high again, with the second rise hitting pending on the same edge as ack of irq_id 2 -> pending_q[2] = 1 after ack; the source is re-presented after eoi.
- Reset mid-service: assert reset in SERVICE with pending_q = 0110 -> asynchronously irq = 0, in_service = 0, pending_q = 0, mask_q = 1111.

Source files
------------

// File: rtl/int_controller.sv
// ---------------------------------------------------------------------------
// int_controller
//
// Purpose:
//   Interrupt controller that sits between the interrupt sources and the CPU
//   core. Each raw level source is synchronised and edge-detected, and every
//   rising edge is latched as pending. Pending sources are masked and
//   prioritised (bit 0 highest). One interrupt at a time is presented to the
//   CPU over an irq/ack/eoi handshake.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   int_in     in   raw level sources: 0=t1, 1=t2, 2=uart_rx, 3=frameDrawn
//   mask_we    in   one-cycle write strobe for the mask register
//   mask_d     in   new mask value (1 = source enabled)
//   mask_q     out  current mask
//   pending_q  out  current pending bits (not masked)
//   irq        out  registered interrupt request to the CPU
//   irq_id     out  index of the presented source, valid while irq = 1
//   ack        in   CPU accepts the presented interrupt (one-cycle pulse)
//   eoi        in   end of interrupt (one-cycle pulse)
//   in_service out  high from the accepted ack until eoi
// ---------------------------------------------------------------------------
module int_controller #(
    parameter int               N_INT       = 4,
    parameter int               ID_W        = 2,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_INT-1:0] MASK_RESET  = {N_INT{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_INT-1:0] int_in,
    input  logic             mask_we,
    input  logic [N_INT-1:0] mask_d,
    output logic [N_INT-1:0] mask_q,
    output logic [N_INT-1:0] pending_q,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id,
    input  logic             ack,
    input  logic             eoi,
    output logic             in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   irq_id_q, irq_id_d;
    logic [N_INT-1:0]  sync_s;       // last flop of every synchroniser chain
    logic [N_INT-1:0]  delay_q;      // previous value of sync_s
    logic [N_INT-1:0]  rise;
    logic [N_INT-1:0]  clr;
    logic [N_INT-1:0]  pending_d;
    logic [N_INT-1:0]  cand;
    logic [ID_W-1:0]   sel;

    // ------------------------------------------------------------------
    // Per-source synchroniser chain and acknowledge-clear decode.
    // frameDrawn comes from the vga_clk domain, so every source gets the
    // same multi-flop chain for uniform latency.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_INT; gi++) begin : g_src
            logic [SYNC_STAGES-1:0] chain_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    chain_q <= '0;
                end else begin
                    chain_q[0] <= int_in[gi];
                    for (int j = 1; j < SYNC_STAGES; j++) begin
                        chain_q[j] <= chain_q[j-1];
                    end
                end
            end

            assign sync_s[gi] = chain_q[SYNC_STAGES-1];
            // Only an ack that meets a live request clears its source.
            assign clr[gi]    = ack & irq & (irq_id_q == ID_W'(gi));
        end
    endgenerate

    assign rise = sync_s & ~delay_q;

    // Set wins over clear: a new rise on the source being acked in the same
    // cycle keeps it pending, so that edge is never lost.
    assign pending_d = (pending_q & ~clr) | rise;

    // ------------------------------------------------------------------
    // Candidate selection: lowest enabled pending index wins.
    // ------------------------------------------------------------------
    assign cand = pending_q & mask_q;

    always_comb begin
        sel = '0;
        for (int i = N_INT - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel = ID_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM, next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                // irq is low here, so no ack can be accepted in this state.
                if (|cand) begin
                    state_d  = ST_PRESENT;
                    irq_id_d = sel;
                end
            end
            ST_PRESENT: begin
                // irq_id stays frozen; eoi is meaningless here.
                if (ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, pending, edge-detect and mask registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            irq_id_q  <= '0;
            delay_q   <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RESET;
        end else begin
            state_q   <= state_d;
            irq_id_q  <= irq_id_d;
            delay_q   <= sync_s;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_d;
            end
        end
    end

    // Outputs come straight from the state register, so they are glitch-free.
    assign irq        = (state_q == ST_PRESENT);
    assign in_service = (state_q == ST_SERVICE);
    assign irq_id     = irq_id_q;

endmodule

// File: tb/tb_int_controller.sv
// ---------------------------------------------------------------------------
// tb_int_controller
//
// Purpose:
//   Directed testbench for int_controller. Inputs are driven 1 time unit
//   after each rising clock edge and outputs are sampled at the same point,
//   away from the active edge. Expected values are hand-computed from the
//   documented latency: a rise sampled at edge k sets pending at edge k+2
//   and raises irq at edge k+3 (SYNC_STAGES = 2).
// ---------------------------------------------------------------------------
module tb_int_controller;

    logic       clk;
    logic       reset;
    logic [3:0] int_in;
    logic       mask_we;
    logic [3:0] mask_d;
    logic [3:0] mask_q;
    logic [3:0] pending_q;
    logic       irq;
    logic [1:0] irq_id;
    logic       ack;
    logic       eoi;
    logic       in_service;

    int tests_run;
    int tests_failed;

    int_controller #(
        .N_INT       (4),
        .ID_W        (2),
        .SYNC_STAGES (2),
        .MASK_RESET  (4'b1111)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .int_in     (int_in),
        .mask_we    (mask_we),
        .mask_d     (mask_d),
        .mask_q     (mask_q),
        .pending_q  (pending_q),
        .irq        (irq),
        .irq_id     (irq_id),
        .ack        (ack),
        .eoi        (eoi),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_d  = m;
        mask_we = 1'b1;
        tick(1);
        mask_we = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b1;
        int_in  = 4'b0000;
        mask_we = 1'b0;
        mask_d  = 4'b0000;
        ack     = 1'b0;
        eoi     = 1'b0;

        // ---------------- reset state ----------------
        tick(2);
        check_val("rst_irq",        irq,        0);
        check_val("rst_irq_id",     irq_id,     0);
        check_val("rst_in_service", in_service, 0);
        check_val("rst_pending",    pending_q,  0);
        check_val("rst_mask",       mask_q,     4'b1111);
        reset = 1'b0;
        tick(1);

        // ---------------- single source ----------------
        int_in = 4'b0001;
        tick(2);                                   // edges k, k+1
        check_val("t1_pend_early", pending_q, 4'b0000);
        tick(1);                                   // edge k+2
        check_val("t1_pend",       pending_q, 4'b0001);
        check_val("t1_irq_early",  irq,       0);
        tick(1);                                   // edge k+3
        check_val("t1_irq",        irq,       1);
        check_val("t1_irq_id",     irq_id,    0);
        tick(2);
        check_val("t1_irq_hold",   irq,       1);
        pulse_ack();
        check_val("t1_ack_irq",    irq,        0);
        check_val("t1_ack_svc",    in_service, 1);
        check_val("t1_ack_pend",   pending_q,  4'b0000);
        pulse_ack();                               // ack outside PRESENT
        check_val("t1_stray_ack_svc", in_service, 1);
        check_val("t1_stray_ack_irq", irq,        0);
        pulse_eoi();
        check_val("t1_eoi_svc",    in_service, 0);
        pulse_eoi();                               // eoi outside SERVICE
        tick(3);
        check_val("t1_no_reirq",   irq,        0);
        check_val("t1_idle_svc",   in_service, 0);
        int_in = 4'b0000;
        tick(4);

        // ---------------- priority ----------------
        int_in = 4'b1010;
        tick(3);
        check_val("pr_pend",   pending_q, 4'b1010);
        tick(1);
        check_val("pr_irq",    irq,       1);
        check_val("pr_irq_id", irq_id,    1);
        pulse_ack();
        check_val("pr_ack_pend", pending_q, 4'b1000);
        check_val("pr_ack_irq",  irq,       0);
        pulse_eoi();
        check_val("pr_eoi_irq",  irq,       0);
        tick(1);
        check_val("pr_re_irq",    irq,    1);
        check_val("pr_re_irq_id", irq_id, 3);
        pulse_ack();
        pulse_eoi();
        int_in = 4'b0000;
        tick(4);
        check_val("pr_end_irq",  irq,       0);
        check_val("pr_end_pend", pending_q, 4'b0000);

        // ---------------- freeze ----------------
        int_in = 4'b0100;
        tick(4);
        check_val("fz_irq_id", irq_id, 2);
        int_in = 4'b0101;                          // bit 0 rises while presenting
        tick(4);
        check_val("fz_hold_irq",    irq,       1);
        check_val("fz_hold_irq_id", irq_id,    2);
        check_val("fz_pend",        pending_q, 4'b0101);
        pulse_ack();
        check_val("fz_ack_pend",    pending_q, 4'b0001);
        pulse_eoi();
        tick(1);
        check_val("fz_next_irq",    irq,    1);
        check_val("fz_next_irq_id", irq_id, 0);
        pulse_ack();
        pulse_eoi();
        int_in = 4'b0000;
        tick(4);

        // ---------------- mask ----------------
        write_mask(4'b0111);
        check_val("mk_mask", mask_q, 4'b0111);
        int_in = 4'b1000;
        tick(5);
        check_val("mk_pend",       pending_q, 4'b1000);
        check_val("mk_irq_masked", irq,       0);
        write_mask(4'b1111);
        check_val("mk_mask_all",   mask_q,    4'b1111);
        check_val("mk_irq_pre",    irq,       0);
        tick(1);
        check_val("mk_irq",        irq,       1);
        check_val("mk_irq_id",     irq_id,    3);
        pulse_ack();
        pulse_eoi();
        int_in = 4'b0000;
        tick(4);

        // ---------------- set wins over ack clear ----------------
        int_in = 4'b0100;
        tick(1);                                   // edge k: first rise sampled
        int_in = 4'b0000;
        tick(1);                                   // edge k+1: low sampled
        int_in = 4'b0100;
        tick(1);                                   // edge k+2: second rise sampled
        int_in = 4'b0000;
        check_val("sw_pend1",   pending_q, 4'b0100);
        tick(1);                                   // edge k+3
        check_val("sw_irq",     irq,    1);
        check_val("sw_irq_id",  irq_id, 2);
        pulse_ack();                               // edge k+4: ack and second rise
        check_val("sw_ack_svc",  in_service, 1);
        check_val("sw_ack_pend", pending_q,  4'b0100);
        pulse_eoi();
        tick(1);
        check_val("sw_re_irq",    irq,    1);
        check_val("sw_re_irq_id", irq_id, 2);
        pulse_ack();
        check_val("sw_clr_pend",  pending_q, 4'b0000);
        pulse_eoi();
        tick(4);

        // ---------------- reset mid-service ----------------
        write_mask(4'b0001);
        int_in = 4'b0111;
        tick(4);
        check_val("rs_irq_id",   irq_id,    0);
        pulse_ack();
        tick(1);
        check_val("rs_svc",      in_service, 1);
        check_val("rs_pend",     pending_q,  4'b0110);
        check_val("rs_mask_pre", mask_q,     4'b0001);
        reset = 1'b1;
        #2;                                        // before the next clock edge
        check_val("rs_async_svc",  in_service, 0);
        check_val("rs_async_irq",  irq,        0);
        check_val("rs_async_pend", pending_q,  4'b0000);
        check_val("rs_async_mask", mask_q,     4'b1111);
        int_in = 4'b0000;
        tick(2);
        reset = 1'b0;
        tick(4);
        check_val("rs_after_irq",  irq, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
